// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package seq_mult_pkg;

  localparam int unsigned SEQ_MULT_WIDTH = 8;
  localparam int unsigned SEQ_MULT_CNT_W = $clog2(SEQ_MULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Step counter must stay at least one bit wide for degenerate widths
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Accumulator, multiplicand latch and one add/shift step per enabled cycle.
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_MULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_a_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic [2*WIDTH-1:0] o_acc_next
);

  logic [2*WIDTH:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH:0]   w_sum;

  // Upper half plus carry bit; the carry bit is always zero here after a shift
  always_comb begin
    w_sum = r_acc[2*WIDTH:WIDTH];
    if (r_acc[0]) begin
      w_sum = r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand};
    end
  end

  // Shifted accumulator without its always-zero top bit
  assign o_acc_next = {w_sum, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_a_n) begin
    if (!reset_a_n) begin
      r_acc   <= '0;
      r_mcand <= '0;
    end else if (i_load) begin
      r_acc   <= {{(WIDTH + 1){1'b0}}, i_mplier};
      r_mcand <= i_mcand;
    end else if (i_step) begin
      r_acc   <= {1'b0, o_acc_next};
    end
  end

endmodule

// File: rtl/seq_mult_core.sv
// Sequential multiplier control: FSM, step counter and registered outputs that
// drive the downstream product register (datain, clock-enable, sync clear).
module seq_mult_core
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_MULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_a_n,
  input  logic               start,
  input  logic               clr_req,
  input  logic [WIDTH-1:0]   dataa,
  input  logic [WIDTH-1:0]   datab,
  output logic [2*WIDTH-1:0] product,
  output logic               reg_clk_ena,
  output logic               reg_sclr_n,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e                r_state;
  logic [CntW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]    r_product;
  logic                  r_clk_ena;
  logic                  r_sclr_n;
  logic                  r_done;
  logic                  w_load;
  logic                  w_step;
  logic [2*WIDTH-1:0]    w_acc_next;

  // Clear requests win over start in IDLE and abort an in-flight CALC
  assign w_load = (r_state == IDLE) && start && !clr_req;
  assign w_step = (r_state == CALC) && !clr_req;

  seq_mult_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk        (clk),
    .reset_a_n  (reset_a_n),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_mcand    (dataa),
    .i_mplier   (datab),
    .o_acc_next (w_acc_next)
  );

  always_ff @(posedge clk or negedge reset_a_n) begin
    if (!reset_a_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_product <= '0;
      r_clk_ena <= 1'b0;
      r_sclr_n  <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_clk_ena <= 1'b0;
      r_sclr_n  <= 1'b1;
      r_done    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_clk_ena <= 1'b1;
            r_sclr_n  <= 1'b0;
          end else if (start) begin
            r_cnt   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (clr_req) begin
            r_clk_ena <= 1'b1;
            r_sclr_n  <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LastCnt) begin
              r_product <= w_acc_next;
              r_state   <= DONE;
            end
          end
        end
        DONE: begin
          r_done    <= 1'b1;
          r_clk_ena <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign product     = r_product;
  assign reg_clk_ena = r_clk_ena;
  assign reg_sclr_n  = r_sclr_n;
  assign done        = r_done;
  assign busy        = (r_state == CALC) || (r_state == DONE);

endmodule

// File: tb/tb_seq_mult_core.sv
// Randomised and directed bench for seq_mult_core with a model of the
// downstream product register it feeds.
module tb_seq_mult_core;

  localparam int unsigned WIDTH = 8;

  logic               clk = 1'b0;
  logic               reset_a_n;
  logic               start;
  logic               clr_req;
  logic [WIDTH-1:0]   dataa;
  logic [WIDTH-1:0]   datab;
  logic [2*WIDTH-1:0] product;
  logic               reg_clk_ena;
  logic               reg_sclr_n;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] reg_out;

  int n_chk = 0;
  int n_err = 0;

  seq_mult_core #(
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .reset_a_n   (reset_a_n),
    .start       (start),
    .clr_req     (clr_req),
    .dataa       (dataa),
    .datab       (datab),
    .product     (product),
    .reg_clk_ena (reg_clk_ena),
    .reg_sclr_n  (reg_sclr_n),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Downstream register: clear is gated by enable
  always @(posedge clk or negedge reset_a_n) begin
    if (!reset_a_n) reg_out <= '0;
    else if (reg_clk_ena) reg_out <= reg_sclr_n ? product : '0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_a_n && !reg_sclr_n) check("sclr_without_ena", reg_clk_ena, 1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: product = a*b, done exactly WIDTH+1 edges after the start edge
  task automatic run_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit scramble);
    logic [2*WIDTH-1:0] exp_p;
    logic [2*WIDTH-1:0] prev_p;
    int lat;
    exp_p  = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    prev_p = product;
    dataa  = a;
    datab  = b;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("busy_calc", busy, 1);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (scramble) begin
        dataa = WIDTH'($urandom);
        datab = WIDTH'($urandom);
      end
      tick();
      if (done) lat = k;
      else if (k == WIDTH - 1) check("product_hold", product, prev_p);
    end
    check("latency", lat, WIDTH + 1);
    check("product", product, exp_p);
    check("done_ena", reg_clk_ena, 1);
    check("done_sclr_n", reg_sclr_n, 1);
    tick();
    check("reg_out", reg_out, exp_p);
    check("done_single", done, 0);
  endtask

  task automatic watch_no_done(input int cycles, output int n_done);
    n_done = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (done) n_done++;
    end
  endtask

  initial begin
    int n_done;
    logic [2*WIDTH-1:0] prev_p;
    reset_a_n = 1'b0;
    start     = 1'b0;
    clr_req   = 1'b0;
    dataa     = '0;
    datab     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_product", product, 0);
    check("rst_ena", reg_clk_ena, 0);
    check("rst_sclr_n", reg_sclr_n, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    reset_a_n = 1'b1;

    run_mult(8'hFF, 8'hFF, 1'b0);
    run_mult(8'h00, 8'hAB, 1'b0);
    run_mult(8'h01, 8'hAB, 1'b0);

    // Restart while busy must be ignored
    dataa = 8'h12;
    datab = 8'h34;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    dataa = 8'hFF;
    datab = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_done = (done) ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) begin
        n_done++;
        check("restart_product", product, 16'h03A8);
      end
    end
    check("restart_ndone", n_done, 1);
    check("restart_product_final", product, 16'h03A8);

    // Clear and start together in IDLE: clear wins
    dataa   = 8'h05;
    datab   = 8'h07;
    start   = 1'b1;
    clr_req = 1'b1;
    tick();
    start   = 1'b0;
    clr_req = 1'b0;
    check("idle_clr_ena", reg_clk_ena, 1);
    check("idle_clr_sclr_n", reg_sclr_n, 0);
    check("idle_clr_busy", busy, 0);
    tick();
    check("idle_clr_ena_off", reg_clk_ena, 0);
    check("idle_clr_reg_out", reg_out, 0);
    watch_no_done(12, n_done);
    check("idle_clr_ndone", n_done, 0);
    check("idle_clr_busy_after", busy, 0);

    // Abort mid-CALC
    run_mult(8'h0B, 8'h0D, 1'b0);
    prev_p  = product;
    dataa   = 8'hFF;
    datab   = 8'hFF;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ena", reg_clk_ena, 1);
    check("abort_sclr_n", reg_sclr_n, 0);
    check("abort_product", product, prev_p);
    watch_no_done(12, n_done);
    check("abort_ndone", n_done, 0);
    check("abort_reg_out", reg_out, 0);
    check("abort_product_kept", product, prev_p);

    // Asynchronous reset between edges in CALC
    run_mult(8'h21, 8'h03, 1'b0);
    dataa = 8'hAB;
    datab = 8'hCD;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    reset_a_n = 1'b0;
    #1;
    check("arst_product", product, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ena", reg_clk_ena, 0);
    check("arst_sclr_n", reg_sclr_n, 1);
    @(negedge clk);
    reset_a_n = 1'b1;
    run_mult(8'h0F, 8'h10, 1'b0);

    // Random operands, source toggles inputs during CALC
    for (int i = 0; i < 24; i++) begin
      run_mult(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        dataa = WIDTH'($urandom);
        tick();
        check("idle_busy", busy, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
